mips_alu: RTL and testbench

MIPS_ALU -- requirements
Module: mips_alu

---
 rtl/mips_alu_pkg.sv | 25 ++
 rtl/mips_alu_if.sv | 42 ++++
 rtl/mips_alu_mux2.sv | 19 +
 rtl/mips_alu.sv | 86 ++++++++
 tb/tb_mips_alu.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mips_alu_pkg.sv
// ============================================================================
//  Module      : mips_alu_pkg
//  Description : Shared ALUControl opcode constants and default widths for
//                the MIPS execute-stage ALU slice.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package mips_alu_pkg;

    localparam int c_DW = 32;
    localparam int c_RW = 5;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SLL = 3'b011;
    localparam logic [2:0] c_ALU_SRL = 3'b100;
    localparam logic [2:0] c_ALU_SRA = 3'b101;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mips_alu_if.sv
// ============================================================================
//  Module      : mips_alu_if
//  Description : Execute-stage operand/control bundle and E/M result bus
//                of the MIPS ALU.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

interface mips_alu_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic [2:0]    ALUControlE;
    logic          ALUSrcE;
    logic          RegDstE;
    logic [RW-1:0] shamtE;
    logic [RW-1:0] RtE;
    logic [RW-1:0] RdE;
    logic [DW-1:0] SrcAE;
    logic [DW-1:0] WriteDataE;
    logic [DW-1:0] SignImmE;
    logic [DW-1:0] ALUOutE;
    logic          ZeroE;
    logic [RW-1:0] WriteRegE;
    logic [DW-1:0] ALUOutM;
    logic          ZeroM;
    logic [RW-1:0] WriteRegM;

    modport master (
        output ALUControlE, ALUSrcE, RegDstE, shamtE, RtE, RdE,
               SrcAE, WriteDataE, SignImmE,
        input  ALUOutE, ZeroE, WriteRegE, ALUOutM, ZeroM, WriteRegM
    );

    modport slave (
        input  ALUControlE, ALUSrcE, RegDstE, shamtE, RtE, RdE,
               SrcAE, WriteDataE, SignImmE,
        output ALUOutE, ZeroE, WriteRegE, ALUOutM, ZeroM, WriteRegM
    );
endinterface

`default_nettype wire

// File: rtl/mips_alu_mux2.sv
// ============================================================================
//  Module      : mux2
//  Description : Width-parameterised 2:1 multiplexer (sel=1 picks d1).
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module mux2 #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] d0,
    input  wire logic [WIDTH-1:0] d1,
    input  wire logic             sel,
    output logic      [WIDTH-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

`default_nettype wire

// File: rtl/mips_alu.sv
// ============================================================================
//  Module      : mips_alu
//  Description : MIPS execute-stage ALU with operand-B / destination muxes and
//                an E->M pipeline register.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module mips_alu
    import mips_alu_pkg::*;
#(
    parameter int DW = c_DW,
    parameter int RW = c_RW
) (
    input wire logic  clk,
    input wire logic  reset,
    mips_alu_if.slave bus
);

    logic [DW-1:0]        w_srcB;
    logic [RW-1:0]        w_writeReg;
    logic [DW-1:0]        w_aluOut;
    logic                 w_zero;
    logic signed [DW-1:0] w_sra;

    logic [DW-1:0] r_aluOutM;
    logic          r_zeroM;
    logic [RW-1:0] r_writeRegM;

    mux2 #(.WIDTH(DW)) u_srcBMux (
        .d0  (bus.WriteDataE),
        .d1  (bus.SignImmE),
        .sel (bus.ALUSrcE),
        .y   (w_srcB)
    );

    mux2 #(.WIDTH(RW)) u_writeRegMux (
        .d0  (bus.RtE),
        .d1  (bus.RdE),
        .sel (bus.RegDstE),
        .y   (w_writeReg)
    );

    assign w_sra = $signed(w_srcB) >>> bus.shamtE;

    // SLT uses a true signed compare so it stays correct when A-B overflows.
    always_comb begin
        w_aluOut = '0;
        case (bus.ALUControlE)
            c_ALU_AND: w_aluOut = bus.SrcAE & w_srcB;
            c_ALU_OR:  w_aluOut = bus.SrcAE | w_srcB;
            c_ALU_ADD: w_aluOut = bus.SrcAE + w_srcB;
            c_ALU_SLL: w_aluOut = w_srcB << bus.shamtE;
            c_ALU_SRL: w_aluOut = w_srcB >> bus.shamtE;
            c_ALU_SRA: w_aluOut = w_sra;
            c_ALU_SUB: w_aluOut = bus.SrcAE - w_srcB;
            c_ALU_SLT: w_aluOut = {{(DW-1){1'b0}},
                                   ($signed(bus.SrcAE) < $signed(w_srcB))};
            default:   w_aluOut = '0;
        endcase
    end

    assign w_zero = (w_aluOut == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluOutM   <= '0;
            r_zeroM     <= 1'b0;
            r_writeRegM <= '0;
        end else begin
            r_aluOutM   <= w_aluOut;
            r_zeroM     <= w_zero;
            r_writeRegM <= w_writeReg;
        end
    end

    assign bus.ALUOutE   = w_aluOut;
    assign bus.ZeroE     = w_zero;
    assign bus.WriteRegE = w_writeReg;
    assign bus.ALUOutM   = r_aluOutM;
    assign bus.ZeroM     = r_zeroM;
    assign bus.WriteRegM = r_writeRegM;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu.sv
// ============================================================================
//  Module      : tb_mips_alu
//  Description : Table-driven self-checking bench for mips_alu.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_mips_alu;

    typedef struct {
        logic [2:0]  op;
        logic        aluSrc;
        logic        regDst;
        logic [4:0]  shamt;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] imm;
        logic [31:0] expOut;
        logic        expZero;
        logic [4:0]  expWr;
    } vec_t;

    logic clk;
    logic reset;
    int   passCnt;
    int   totalCnt;

    mips_alu_if #(.DW(32), .RW(5)) bus ();

    mips_alu #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        bus.ALUControlE = v.op;
        bus.ALUSrcE     = v.aluSrc;
        bus.RegDstE     = v.regDst;
        bus.shamtE      = v.shamt;
        bus.RtE         = v.rt;
        bus.RdE         = v.rd;
        bus.SrcAE       = v.a;
        bus.WriteDataE  = v.wd;
        bus.SignImmE    = v.imm;
    endtask

    vec_t vecs[16];

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        //           op    src  dst  sh  rt  rd   a             wd            imm           expOut        z     wr
        vecs[0]  = '{3'b010, 1, 0, 0, 3, 17, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000004, 0, 3};
        vecs[1]  = '{3'b110, 0, 1, 0, 3, 17, 32'h00001234, 32'h00001234, 32'h00000000, 32'h00000000, 1, 17};
        vecs[2]  = '{3'b111, 0, 0, 0, 4, 9,  32'h80000000, 32'h00000001, 32'h00000000, 32'h00000001, 0, 4};
        vecs[3]  = '{3'b111, 0, 0, 0, 4, 9,  32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 1, 4};
        vecs[4]  = '{3'b111, 0, 1, 0, 4, 9,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000, 1, 9};
        vecs[5]  = '{3'b011, 0, 0, 4, 1, 2,  32'hFFFFFFFF, 32'h80000001, 32'h00000000, 32'h00000010, 0, 1};
        vecs[6]  = '{3'b100, 0, 0, 4, 1, 2,  32'hFFFFFFFF, 32'h80000001, 32'h00000000, 32'h08000000, 0, 1};
        vecs[7]  = '{3'b101, 0, 0, 4, 1, 2,  32'h00000000, 32'h80000001, 32'h00000000, 32'hF8000000, 0, 1};
        vecs[8]  = '{3'b000, 0, 1, 0, 5, 30, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hF000F000, 0, 30};
        vecs[9]  = '{3'b001, 0, 0, 0, 5, 30, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 32'hFFFFFFFF, 0, 5};
        vecs[10] = '{3'b011, 0, 0, 0, 6, 7,  32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'h12345678, 0, 6};
        vecs[11] = '{3'b010, 0, 0, 0, 6, 7,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1, 6};
        vecs[12] = '{3'b110, 0, 1, 0, 6, 7,  32'h00000000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 0, 7};
        vecs[13] = '{3'b101, 0, 0, 31, 0, 31, 32'h00000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 0, 0};
        vecs[14] = '{3'b100, 0, 1, 31, 0, 31, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000001, 0, 31};
        vecs[15] = '{3'b001, 1, 0, 0, 8, 2,  32'h00000000, 32'h0000FFFF, 32'h00000100, 32'h00000100, 0, 8};

        // Reset state
        reset = 1'b1;
        apply(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ALUOutM",   bus.ALUOutM,          32'h0);
        check("rst_ZeroM",     {31'b0, bus.ZeroM},   32'h0);
        check("rst_WriteRegM", {27'b0, bus.WriteRegM}, 32'h0);
        check("rst_ALUOutE",   bus.ALUOutE,          32'h4);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #1;
            check($sformatf("v%0d_ALUOutE", i),   bus.ALUOutE,               vecs[i].expOut);
            check($sformatf("v%0d_ZeroE", i),     {31'b0, bus.ZeroE},        {31'b0, vecs[i].expZero});
            check($sformatf("v%0d_WriteRegE", i), {27'b0, bus.WriteRegE},    {27'b0, vecs[i].expWr});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ALUOutM", i),   bus.ALUOutM,               vecs[i].expOut);
            check($sformatf("v%0d_ZeroM", i),     {31'b0, bus.ZeroM},        {31'b0, vecs[i].expZero});
            check($sformatf("v%0d_WriteRegM", i), {27'b0, bus.WriteRegM},    {27'b0, vecs[i].expWr});
        end

        // Destination mux toggled back-to-back, M follows one edge later
        apply('{3'b010, 0, 0, 0, 3, 17, 32'h1, 32'h1, 32'h0, 32'h2, 0, 3});
        @(posedge clk);
        #1;
        bus.RegDstE = 1'b1;
        #1;
        check("dst_WriteRegE_rd", {27'b0, bus.WriteRegE}, 32'd17);
        check("dst_WriteRegM_old", {27'b0, bus.WriteRegM}, 32'd3);
        @(posedge clk);
        #1;
        check("dst_WriteRegM_rd", {27'b0, bus.WriteRegM}, 32'd17);

        // Preload DEADBEEF, then reset for one edge while inputs stay live
        apply('{3'b001, 0, 0, 0, 9, 10, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 0, 9});
        @(posedge clk);
        #1;
        check("pre_ALUOutM",   bus.ALUOutM,            32'hDEADBEEF);
        check("pre_WriteRegM", {27'b0, bus.WriteRegM}, 32'd9);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_ALUOutM",   bus.ALUOutM,            32'h0);
        check("rst2_ZeroM",     {31'b0, bus.ZeroM},     32'h0);
        check("rst2_WriteRegM", {27'b0, bus.WriteRegM}, 32'h0);
        check("rst2_ALUOutE",   bus.ALUOutE,            32'hDEADBEEF);
        check("rst2_WriteRegE", {27'b0, bus.WriteRegE}, 32'd9);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("resume_ALUOutM",   bus.ALUOutM,            32'hDEADBEEF);
        check("resume_WriteRegM", {27'b0, bus.WriteRegM}, 32'd9);

        // Zero result under reset: ZeroM must still be held at 0
        apply('{3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstz_ZeroE", {31'b0, bus.ZeroE}, 32'h1);
        check("rstz_ZeroM", {31'b0, bus.ZeroM}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstz_ZeroM_resume", {31'b0, bus.ZeroM}, 32'h1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

`default_nettype wire
